// File: rtl/merger_lane_feeder_if.sv
// Handshake and bus bundle between the per-lane upstream sources, the lane feeder and the merger.
// The master modport is the feeder's view; the slave modport is the environment's view.
interface merger_lane_feeder_if #(
  parameter int COORD_BITS = 8,
  parameter int RADIX      = 4
);
  logic                        start;
  logic [RADIX-1:0]            in_valid;
  logic [RADIX-1:0]            in_ready;
  logic [RADIX*COORD_BITS-1:0] in_coord;
  logic [RADIX*COORD_BITS-1:0] coord_out;
  logic                        selected;
  logic [RADIX-1:0]            fetch_next;
  logic                        stall;
  logic [RADIX-1:0]            lane_done;
  logic                        done;
  logic                        err;

  modport master (
    input  start, in_valid, in_coord, fetch_next,
    output in_ready, coord_out, selected, stall, lane_done, done, err
  );

  modport slave (
    output start, in_valid, in_coord, fetch_next,
    input  in_ready, coord_out, selected, stall, lane_done, done, err
  );
endinterface

// File: rtl/merger_lane_feeder.sv
// Leaf-side feeder for the radix-R coordinate merger: per-lane FIFOs, head presentation, issue/pop pacing.
// Optional protocol checking on fetch_next is built when MERGER_FEEDER_ERR_EN is defined.
module merger_lane_feeder #(
  parameter int COORD_BITS = 8,
  parameter int RADIX      = 4,
  parameter int DEPTH      = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  merger_lane_feeder_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [COORD_BITS-1:0] SENTINEL = '1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state, stateNext;
  logic [COORD_BITS-1:0] fifoMem [RADIX][DEPTH];
  logic [PTR_W-1:0]      rdPtr   [RADIX];
  logic [PTR_W-1:0]      wrPtr   [RADIX];
  logic [CNT_W-1:0]      count   [RADIX];
  logic [RADIX-1:0]      lastSeen, laneEmpty, laneFull, laneDone;
  logic [RADIX-1:0]      pushEn, markEn, popEn;
  logic                  fetchOneHot, allDone, stallNow, issueNow;

  assign fetchOneHot = (bus.fetch_next != '0) &&
                       ((bus.fetch_next & (bus.fetch_next - RADIX'(1))) == '0);

  // in_ready depends only on registered state, so a pop in the same cycle cannot open a full lane
  always_comb begin
    laneEmpty     = '0;
    laneFull      = '0;
    laneDone      = '0;
    pushEn        = '0;
    markEn        = '0;
    popEn         = '0;
    bus.coord_out = '1;
    for (int i = 0; i < RADIX; i++) begin
      laneEmpty[i] = (count[i] == '0);
      laneFull[i]  = (count[i] == CNT_W'(DEPTH));
      laneDone[i]  = lastSeen[i] & laneEmpty[i];
      markEn[i]    = bus.in_valid[i] & ~lastSeen[i] & ~laneFull[i] &
                     (bus.in_coord[i*COORD_BITS +: COORD_BITS] == SENTINEL);
      pushEn[i]    = bus.in_valid[i] & ~lastSeen[i] & ~laneFull[i] &
                     (bus.in_coord[i*COORD_BITS +: COORD_BITS] != SENTINEL);
      popEn[i]     = (state == WAIT) & fetchOneHot & bus.fetch_next[i] & ~laneEmpty[i];
      if (!laneEmpty[i]) begin
        bus.coord_out[i*COORD_BITS +: COORD_BITS] = fifoMem[i][rdPtr[i]];
      end
    end
  end

  assign allDone       = &laneDone;
  assign stallNow      = (state == ISSUE) && (|(laneEmpty & ~lastSeen));
  assign issueNow      = (state == ISSUE) && !allDone && !stallNow;
  assign bus.in_ready  = ~lastSeen & ~laneFull;
  assign bus.stall     = stallNow;
  assign bus.selected  = issueNow;
  assign bus.lane_done = laneDone;
  assign bus.done      = (state == DONE);

  // Issue and wait alternate so a head is never reselected before the merger's pop lands
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start) stateNext = ISSUE;
      ISSUE:   if (allDone) stateNext = DONE;
               else if (!stallNow) stateNext = WAIT;
      WAIT:    stateNext = ISSUE;
      DONE:    if (bus.start) stateNext = ISSUE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      lastSeen <= '0;
      for (int i = 0; i < RADIX; i++) begin
        rdPtr[i] <= '0;
        wrPtr[i] <= '0;
        count[i] <= '0;
      end
    end else begin
      state <= stateNext;
      if (state == DONE && bus.start) begin
        lastSeen <= '0;
      end else begin
        lastSeen <= lastSeen | markEn;
      end
      for (int i = 0; i < RADIX; i++) begin
        if (pushEn[i]) wrPtr[i] <= wrPtr[i] + PTR_W'(1);
        if (popEn[i])  rdPtr[i] <= rdPtr[i] + PTR_W'(1);
        case ({pushEn[i], popEn[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Storage has no reset; stale entries are unreachable once counts and pointers clear
  always_ff @(posedge clock) begin
    for (int i = 0; i < RADIX; i++) begin
      if (pushEn[i]) fifoMem[i][wrPtr[i]] <= bus.in_coord[i*COORD_BITS +: COORD_BITS];
    end
  end

`ifdef MERGER_FEEDER_ERR_EN
  logic errReg, errEvent;

  always_comb begin
    errEvent = 1'b0;
    if (state != WAIT) begin
      errEvent = (bus.fetch_next != '0);
    end else begin
      errEvent = !fetchOneHot || ((bus.fetch_next & ~laneEmpty) == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      errReg <= 1'b0;
    end else if (errEvent) begin
      errReg <= 1'b1;
    end
  end

  assign bus.err = errReg;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_merger_lane_feeder.sv
// Self-checking bench for merger_lane_feeder with a registered min-select merger model attached.
// Expected merge output is the sorted union of the lane streams; err expectation follows MERGER_FEEDER_ERR_EN.
module tb_merger_lane_feeder;
  localparam int CB = 8;
  localparam int R  = 4;
`ifdef MERGER_FEEDER_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic       forceEn;
  logic [3:0] forceVal;
  logic [3:0] modelFetch;
  logic       prevSel;
  int         outQ[$];
  int         pickQ[$];
  int         expQ[$];
  int         selCount;
  int         backToBack;

  int laneVals[R][8];
  int laneLen[R];
  int laneIdx[R];

  merger_lane_feeder_if #(.COORD_BITS(CB), .RADIX(R)) bus ();

  merger_lane_feeder #(.COORD_BITS(CB), .RADIX(R), .DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.fetch_next = forceEn ? forceVal : modelFetch;

  // Merger model: picks the smallest head (lowest lane on ties) and returns it one cycle later
  always @(posedge clock) begin
    int best;
    int bestIdx;
    if (reset) begin
      modelFetch <= '0;
      prevSel    <= 1'b0;
    end else begin
      prevSel <= bus.selected;
      if (bus.selected) begin
        best    = 256;
        bestIdx = 0;
        for (int i = 0; i < R; i++) begin
          if (int'(bus.coord_out[i*CB +: CB]) < best) begin
            best    = int'(bus.coord_out[i*CB +: CB]);
            bestIdx = i;
          end
        end
        modelFetch <= 4'(1 << bestIdx);
        outQ.push_back(best);
        pickQ.push_back(bestIdx);
        selCount++;
        if (prevSel) backToBack++;
      end else begin
        modelFetch <= '0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetDut();
    @(negedge clock);
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = '0;
    bus.in_coord = '0;
    forceEn      = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    outQ.delete();
    pickQ.delete();
    expQ.delete();
    selCount   = 0;
    backToBack = 0;
  endtask

  task automatic pushVal(input int lane, input int val);
    int n;
    @(negedge clock);
    bus.in_valid[lane]           = 1'b1;
    bus.in_coord[lane*CB +: CB]  = 8'(val);
    n = 0;
    while (!bus.in_ready[lane] && n < 50) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("push_ready_l%0d", lane), 32'(bus.in_ready[lane]), 32'd1);
    @(posedge clock);
    #1 bus.in_valid[lane] = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(bus.done), 32'd1);
  endtask

  task automatic checkOutQ(input string tag);
    check($sformatf("%s_len", tag), 32'(outQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      check($sformatf("%s_out%0d", tag, i), (i < outQ.size()) ? 32'(outQ[i]) : 32'hFFFF_FFFF,
            32'(expQ[i]));
    end
  endtask

  initial begin
    int n;
    int tmp;
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    forceEn      = 1'b0;
    forceVal     = '0;
    bus.start    = 1'b0;
    bus.in_valid = '0;
    bus.in_coord = '0;
    selCount     = 0;
    backToBack   = 0;
    repeat (2) @(negedge clock);

    $display("[TB] reset state");
    check("rst_in_ready", 32'(bus.in_ready), 32'hF);
    check("rst_coord_out", bus.coord_out, 32'hFFFF_FFFF);
    check("rst_selected", 32'(bus.selected), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_lane_done", 32'(bus.lane_done), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);

    $display("[TB] basic merge");
    resetDut();
    pushVal(0, 8'h01); pushVal(0, 8'h05); pushVal(0, 8'hFF);
    pushVal(1, 8'h02); pushVal(1, 8'hFF);
    pushVal(2, 8'h03); pushVal(2, 8'h04); pushVal(2, 8'hFF);
    pushVal(3, 8'hFF);
    check("basic_l3_done_early", 32'(bus.lane_done), 32'h8);
    check("basic_l3_sentinel", 32'(bus.coord_out[3*CB +: CB]), 32'hFF);
    pulseStart();
    waitDone("basic_done", 200);
    expQ = '{1, 2, 3, 4, 5};
    checkOutQ("basic");
    check("basic_sel_count", 32'(selCount), 32'd5);
    check("basic_alternate", 32'(backToBack), 32'd0);
    check("basic_lane_done", 32'(bus.lane_done), 32'hF);
    check("basic_err", 32'(bus.err), 32'd0);
    pulseStart();
    check("restart_done_low", 32'(bus.done), 32'd0);

    $display("[TB] full lane and held push");
    resetDut();
    pushVal(0, 8'h01); pushVal(0, 8'h02); pushVal(0, 8'h03); pushVal(0, 8'h04);
    pushVal(1, 8'hFF); pushVal(2, 8'hFF); pushVal(3, 8'hFF);
    @(negedge clock);
    check("full_ready0", 32'(bus.in_ready[0]), 32'd0);
    bus.start          = 1'b1;
    bus.in_valid[0]    = 1'b1;
    bus.in_coord[7:0]  = 8'h05;
    @(negedge clock);
    bus.start = 1'b0;
    check("held_issue_ready0", 32'(bus.in_ready[0]), 32'd0);
    check("held_issue_sel", 32'(bus.selected), 32'd1);
    @(negedge clock);
    check("held_wait_ready0", 32'(bus.in_ready[0]), 32'd0);
    @(negedge clock);
    check("held_after_pop_ready0", 32'(bus.in_ready[0]), 32'd1);
    @(negedge clock);
    check("held_accepted_full", 32'(bus.in_ready[0]), 32'd0);
    bus.in_valid[0] = 1'b0;
    pushVal(0, 8'hFF);
    waitDone("held_done", 200);
    expQ = '{1, 2, 3, 4, 5};
    checkOutQ("held");

    $display("[TB] stall on empty lane");
    resetDut();
    pushVal(0, 8'h01); pushVal(0, 8'hFF);
    pushVal(2, 8'hFF); pushVal(3, 8'hFF);
    pulseStart();
    check("stall_hi", 32'(bus.stall), 32'd1);
    check("stall_nosel", 32'(bus.selected), 32'd0);
    @(negedge clock);
    check("stall_hold", 32'(bus.stall), 32'd1);
    pushVal(1, 8'h07);
    @(negedge clock);
    check("unstall_stall", 32'(bus.stall), 32'd0);
    check("unstall_sel", 32'(bus.selected), 32'd1);
    pushVal(1, 8'hFF);
    waitDone("stall_done", 200);
    expQ = '{1, 7};
    checkOutQ("stall");

    $display("[TB] reset mid-run");
    resetDut();
    pushVal(0, 8'h10); pushVal(0, 8'h20); pushVal(1, 8'h15);
    pulseStart();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_coord_out", bus.coord_out, 32'hFFFF_FFFF);
    check("mid_selected", 32'(bus.selected), 32'd0);
    check("mid_in_ready", 32'(bus.in_ready), 32'hF);
    check("mid_done", 32'(bus.done), 32'd0);
    check("mid_lane_done", 32'(bus.lane_done), 32'd0);
    repeat (2) @(negedge clock);
    check("mid_idle_stall", 32'(bus.stall), 32'd0);
    check("mid_idle_sel", 32'(bus.selected), 32'd0);

    $display("[TB] equal heads");
    resetDut();
    pushVal(0, 8'h06); pushVal(0, 8'hFF);
    pushVal(1, 8'h06); pushVal(1, 8'hFF);
    pushVal(2, 8'hFF); pushVal(3, 8'hFF);
    pulseStart();
    waitDone("tie_done", 200);
    expQ = '{6, 6};
    checkOutQ("tie");
    check("tie_pick_count", 32'(pickQ.size()), 32'd2);
    check("tie_pick0", (pickQ.size() > 0) ? 32'(pickQ[0]) : 32'hFFFF_FFFF, 32'd0);
    check("tie_pick1", (pickQ.size() > 1) ? 32'(pickQ[1]) : 32'hFFFF_FFFF, 32'd1);
    check("tie_coord_out", bus.coord_out, 32'hFFFF_FFFF);

    $display("[TB] illegal fetch_next");
    resetDut();
    pushVal(0, 8'h01); pushVal(0, 8'h02); pushVal(0, 8'hFF);
    pushVal(1, 8'hFF); pushVal(2, 8'hFF); pushVal(3, 8'hFF);
    pulseStart();
    n = 0;
    while (!bus.selected && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("err_sel_seen", 32'(bus.selected), 32'd1);
    @(posedge clock);
    #1;
    forceVal = 4'b0011;
    forceEn  = 1'b1;
    @(posedge clock);
    #1 forceEn = 1'b0;
    @(negedge clock);
    check("err_no_pop_head", 32'(bus.coord_out[7:0]), 32'h01);
    check("err_flag", 32'(bus.err), 32'(ERR_EXP));
    waitDone("err_done", 200);
    check("err_sticky", 32'(bus.err), 32'(ERR_EXP));
    resetDut();
    check("err_cleared", 32'(bus.err), 32'd0);

    $display("[TB] randomized merges");
    for (int it = 0; it < 15; it++) begin
      resetDut();
      for (int l = 0; l < R; l++) begin
        laneLen[l] = $urandom_range(0, 6);
        laneIdx[l] = 0;
        for (int k = 0; k < laneLen[l]; k++) begin
          laneVals[l][k] = $urandom_range(0, 254);
          expQ.push_back(laneVals[l][k]);
        end
        for (int a = 0; a < laneLen[l]; a++) begin
          for (int b = 0; b + 1 < laneLen[l] - a; b++) begin
            if (laneVals[l][b] > laneVals[l][b+1]) begin
              tmp              = laneVals[l][b];
              laneVals[l][b]   = laneVals[l][b+1];
              laneVals[l][b+1] = tmp;
            end
          end
        end
        laneVals[l][laneLen[l]] = 255;
      end
      expQ.sort();
      fork
        begin
          int guard;
          logic [R-1:0] accept;
          guard = 0;
          while ((laneIdx[0] <= laneLen[0] || laneIdx[1] <= laneLen[1] ||
                  laneIdx[2] <= laneLen[2] || laneIdx[3] <= laneLen[3]) && guard < 2000) begin
            @(negedge clock);
            guard++;
            for (int l = 0; l < R; l++) begin
              if (laneIdx[l] <= laneLen[l] && $urandom_range(0, 3) != 0) begin
                bus.in_valid[l]        = 1'b1;
                bus.in_coord[l*CB +: CB] = 8'(laneVals[l][laneIdx[l]]);
              end else begin
                bus.in_valid[l] = 1'b0;
              end
              accept[l] = bus.in_valid[l] & bus.in_ready[l];
            end
            @(posedge clock);
            for (int l = 0; l < R; l++) begin
              if (accept[l]) laneIdx[l]++;
            end
          end
          #1 bus.in_valid = '0;
        end
        begin
          repeat ($urandom_range(0, 8)) @(negedge clock);
          pulseStart();
          waitDone($sformatf("rand%0d_done", it), 3000);
        end
      join
      checkOutQ($sformatf("rand%0d", it));
      check($sformatf("rand%0d_lane_done", it), 32'(bus.lane_done), 32'hF);
      check($sformatf("rand%0d_alternate", it), 32'(backToBack), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
